dcache_sa_controller: RTL and testbench



---
 rtl/dcache_pkg.sv | 52 +++++
 rtl/dcache_lru.sv | 39 +++
 rtl/dcache_sa_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_dcache_sa_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FETCH,
        S_UPDATE
    } state_e;

    // Per-set replacement state is kept 3 bits wide so one encoding serves
    // 1, 2 and 4 ways (bit 0 only for 2 ways, full tree for 4 ways).
    localparam int LRU_W = 3;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    // Mark 'way' as most recently used.
    // 2 ways: bit 0 names the LRU way.
    // 4 ways: bit 0 picks the LRU half, bit 1 / bit 2 pick the LRU way
    // inside the low / high pair.
    function automatic logic [LRU_W-1:0] lru_touch(input int ways,
                                                   input logic [LRU_W-1:0] st,
                                                   input logic [1:0] way);
        logic [LRU_W-1:0] n;
        n = st;
        if (ways == 2) begin
            n[0] = ~way[0];
        end else if (ways == 4) begin
            n[0] = ~way[1];
            if (way[1]) n[2] = ~way[0];
            else        n[1] = ~way[0];
        end
        return n;
    endfunction

    // Way the replacement state currently points at.
    function automatic logic [1:0] lru_victim(input int ways,
                                              input logic [LRU_W-1:0] st);
        logic [1:0] v;
        v = 2'd0;
        if (ways == 2)      v = {1'b0, st[0]};
        else if (ways == 4) v = st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
        return v;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set replacement state; one write port for updates, one read port for
// the victim of the set being looked up.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS  = 4,
    parameter int WAYS  = 2,
    parameter int IDX_W = 2,
    parameter int WAY_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [WAY_W-1:0] upd_way,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAY_W-1:0] victim_way
);

    logic [LRU_W-1:0] lru_q [SETS];
    logic [LRU_W-1:0] lru_d;

    // Next state of the set being touched.
    always_comb begin
        lru_d = lru_touch(WAYS, lru_q[upd_idx], 2'(upd_way));
    end

    // Replacement storage; cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) lru_q[s] <= '0;
        end else if (upd_en) begin
            lru_q[upd_idx] <= lru_d;
        end
    end

    assign victim_way = WAY_W'(lru_victim(WAYS, lru_q[rd_idx]));

endmodule

// File: rtl/dcache_sa_controller.sv
// Set-associative write-back / write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds saturating hit/miss/writeback counters.
module dcache_sa_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SETS        = 4,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  read,
    input  logic                                  write,
    input  logic [ADDR_W-1:0]                     address,
    input  logic [DATA_W-1:0]                     writedata,
    output logic [DATA_W-1:0]                     readdata,
    output logic                                  BUSY,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [ADDR_W-clog2(BLOCK_WORDS)-1:0]  mem_address,
    output logic [DATA_W*BLOCK_WORDS-1:0]         mem_writedata,
    input  logic [DATA_W*BLOCK_WORDS-1:0]         mem_readdata,
    input  logic                                  mem_BUSY
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                           hit_count,
    output logic [31:0]                           miss_count,
    output logic [15:0]                           wb_count
`endif
);

    localparam int OFF_W = clog2(BLOCK_WORDS);
    localparam int IDX_W = clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = DATA_W * BLOCK_WORDS;
    localparam int MA_W  = ADDR_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

    logic [TAG_W-1:0] tag_a;
    logic [IDX_W-1:0] idx_a;
    logic [OFF_W-1:0] off_a;
    assign {tag_a, idx_a, off_a} = address;

    logic req;
    assign req = read | write;

    // Line storage
    logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
    logic [BLK_W-1:0]          data_q [SETS][WAYS];

    state_e           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [MA_W-1:0]  mem_address_q, mem_address_d;
    logic [BLK_W-1:0] mem_writedata_q, mem_writedata_d;

    logic             hit;
    logic [WAY_W-1:0] hit_way, vict_sel, lru_way, way_sel;
    logic             found_inv;
    logic [BLK_W-1:0] hit_blk, blk_d;
    logic             hit_commit, fill, blk_we;

    // Tag compare across the ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_a][w] && tag_q[idx_a][w] == tag_a) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way first, replacement state otherwise.
    always_comb begin
        vict_sel  = lru_way;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_q[idx_a][w]) begin
                vict_sel  = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
    end

    assign hit_blk    = data_q[idx_a][hit_way];
    assign BUSY       = (state_q != S_IDLE) || (req && !hit);
    assign readdata   = (read && !BUSY) ? hit_blk[off_a*DATA_W +: DATA_W] : '0;
    assign hit_commit = (state_q == S_IDLE) && req && hit;
    assign fill       = (state_q == S_UPDATE);
    assign blk_we     = fill || (hit_commit && write);
    assign way_sel    = fill ? victim_q : hit_way;

    // Block to store: fill data, or the hit block with the store merged in.
    always_comb begin
        blk_d = hit_blk;
        blk_d[off_a*DATA_W +: DATA_W] = writedata;
        if (fill) blk_d = mem_readdata;
    end

    // Miss sequencing and registered memory-side decodes of the next state.
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    victim_d = vict_sel;
                    state_d  = (valid_q[idx_a][vict_sel] && dirty_q[idx_a][vict_sel])
                               ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: if (!mem_BUSY) state_d = S_FETCH;
            S_FETCH:     if (!mem_BUSY) state_d = S_UPDATE;
            S_UPDATE:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        mem_read_d      = (state_d == S_FETCH);
        mem_write_d     = (state_d == S_WRITEBACK);
        mem_address_d   = '0;
        mem_writedata_d = '0;
        if (state_d == S_WRITEBACK) begin
            mem_address_d   = {tag_q[idx_a][victim_d], idx_a};
            mem_writedata_d = data_q[idx_a][victim_d];
        end else if (state_d == S_FETCH) begin
            mem_address_d   = {tag_a, idx_a};
        end
    end

    // Controller state and memory-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            victim_q        <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            victim_q        <= victim_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    // Valid/dirty bits; a fill installs a clean line, a store hit dirties it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[idx_a][victim_q] <= 1'b1;
            dirty_q[idx_a][victim_q] <= 1'b0;
        end else if (hit_commit && write) begin
            dirty_q[idx_a][hit_way] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clock) begin
        if (blk_we) data_q[idx_a][way_sel] <= blk_d;
        if (fill)   tag_q[idx_a][victim_q] <= tag_a;
    end

    dcache_lru #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clock      (clock),
        .reset      (reset),
        .upd_en     (hit_commit || fill),
        .upd_idx    (idx_a),
        .upd_way    (way_sel),
        .rd_idx     (idx_a),
        .victim_way (lru_way)
    );

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [15:0] wb_count_q, wb_count_d;

    // Saturating event counters: completed hit, FETCH entry, WRITEBACK entry.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (hit_commit && hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
        if (state_d == S_FETCH && state_q != S_FETCH && miss_count_q != '1)
            miss_count_d = miss_count_q + 32'd1;
        if (state_d == S_WRITEBACK && state_q != S_WRITEBACK && wb_count_q != '1)
            wb_count_d = wb_count_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_dcache_sa_controller.sv
// Bench for dcache_sa_controller (defaults: 8-bit address, 4 sets, 2 ways,
// 4-word blocks). A transaction-level cache model with true LRU by use
// stamps predicts every cycle of each request; one process compares.
module tb_dcache_sa_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [7:0]  address = '0, writedata = '0;
    logic [7:0]  readdata;
    logic        BUSY, mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_BUSY = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    logic [15:0] wb_count;
`endif

    dcache_sa_controller dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .BUSY(BUSY), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_BUSY(mem_BUSY)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 clock = ~clock;

    // Per-cycle expectations (driver-owned)
    bit          chk_en = 1'b0;
    bit          exp_busy, exp_mr, exp_mw;
    logic [7:0]  exp_rd;
    logic [5:0]  exp_ma;
    logic [31:0] exp_mwd;
    // Literal checks handed to the compare process
    string       lit_name;
    logic [31:0] lit_act, lit_exp;
    int          lit_seq = 0;

    // Compare-process-owned counters and captures
    int          total = 0, bad = 0, lit_done = 0;
    int          busy_cnt = 0, wb_cnt = 0, fetch_cnt = 0;
    logic [5:0]  cap_fetch = '0, cap_wb_addr = '0;
    logic [31:0] cap_wb_data = '0;
    logic [7:0]  cap_rd = '0;

    // Model state
    logic [31:0] mem [64];
    bit          m_valid [4][2];
    bit          m_dirty [4][2];
    logic [3:0]  m_tag   [4][2];
    logic [31:0] m_data  [4][2];
    int          m_stamp [4][2];
    int          now = 0;

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // The single compare process.
    initial forever begin
        @(negedge clock);
        if (lit_seq != lit_done) begin
            cmp(lit_name, lit_act, lit_exp);
            lit_done = lit_seq;
        end
        if (chk_en) begin
            cmp("BUSY",          32'(BUSY),          32'(exp_busy));
            cmp("readdata",      32'(readdata),      32'(exp_rd));
            cmp("mem_read",      32'(mem_read),      32'(exp_mr));
            cmp("mem_write",     32'(mem_write),     32'(exp_mw));
            cmp("mem_address",   32'(mem_address),   32'(exp_ma));
            cmp("mem_writedata", mem_writedata,      exp_mwd);
            if (BUSY) busy_cnt++;
            if (mem_write) begin
                wb_cnt++;
                cap_wb_addr = mem_address;
                cap_wb_data = mem_writedata;
            end
            if (mem_read) begin
                fetch_cnt++;
                cap_fetch = mem_address;
            end
            if (read && !BUSY) cap_rd = readdata;
        end
    end

    task automatic post_lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        lit_name = nm;
        lit_act  = a;
        lit_exp  = e;
        lit_seq++;
        @(negedge clock);
        #1;
    endtask

    task automatic step(input bit mb, input bit eb, input logic [7:0] erd, input bit emr,
                        input bit emw, input logic [5:0] ema, input logic [31:0] emwd);
        @(posedge clock);
        #1;
        mem_BUSY = mb;
        exp_busy = eb; exp_rd = erd; exp_mr = emr; exp_mw = emw;
        exp_ma = ema; exp_mwd = emwd;
        chk_en = 1'b1;
    endtask

    function automatic int victim_of(input logic [1:0] ix);
        int v;
        v = -1;
        for (int w = 0; w < 2; w++) if (v < 0 && !m_valid[ix][w]) v = w;
        if (v < 0) begin
            v = 0;
            for (int w = 1; w < 2; w++) if (m_stamp[ix][w] < m_stamp[ix][v]) v = w;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        read = 1'b0; write = 1'b0; mem_BUSY = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One CPU request, cycle by cycle, followed by one idle cycle.
    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          input int wbw, input int fw);
        logic [3:0] tg;
        logic [1:0] ix, of;
        logic [5:0] fa;
        int         hw, v;
        tg = a[7:4]; ix = a[3:2]; of = a[1:0];
        hw = -1;
        for (int w = 0; w < 2; w++) if (m_valid[ix][w] && m_tag[ix][w] == tg) hw = w;
        if (hw < 0) begin
            v = victim_of(ix);
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0);
            read = !wr; write = wr; address = a; writedata = wd;
            if (m_valid[ix][v] && m_dirty[ix][v]) begin
                for (int i = 0; i <= wbw; i++)
                    step(i < wbw, 1'b1, 8'h00, 1'b0, 1'b1, {m_tag[ix][v], ix}, m_data[ix][v]);
                mem[{m_tag[ix][v], ix}] = m_data[ix][v];
            end
            fa = {tg, ix};
            for (int i = 0; i <= fw; i++) begin
                step(i < fw, 1'b1, 8'h00, 1'b1, 1'b0, fa, 32'h0);
                mem_readdata = mem[fa];
            end
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0);
            m_valid[ix][v] = 1'b1; m_dirty[ix][v] = 1'b0;
            m_tag[ix][v] = tg; m_data[ix][v] = mem[fa];
            m_stamp[ix][v] = ++now;
            hw = v;
            step(1'b0, 1'b0, wr ? 8'h00 : m_data[ix][hw][of*8 +: 8], 1'b0, 1'b0, 6'h00, 32'h0);
        end else begin
            step(1'b0, 1'b0, wr ? 8'h00 : m_data[ix][hw][of*8 +: 8], 1'b0, 1'b0, 6'h00, 32'h0);
            read = !wr; write = wr; address = a; writedata = wd;
        end
        if (wr) begin
            m_data[ix][hw][of*8 +: 8] = wd;
            m_dirty[ix][hw] = 1'b1;
        end
        m_stamp[ix][hw] = ++now;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0);
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        int b, w, f, vw;
        logic s_mw_pre, s_mw, s_busy;
        logic [5:0] s_ma;
        logic [31:0] s_mwd;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;

        do_reset();
        post_lit("rst_BUSY",        32'(BUSY),        32'h0);
        post_lit("rst_readdata",    32'(readdata),    32'h0);
        post_lit("rst_mem_read",    32'(mem_read),    32'h0);
        post_lit("rst_mem_write",   32'(mem_write),   32'h0);
        post_lit("rst_mem_address", 32'(mem_address), 32'h0);

        // Cold read miss
        b = busy_cnt;
        do_req(1'b0, 8'h00, 8'h00, 0, 0);
        post_lit("t1_fetch_addr", 32'(cap_fetch), 32'h00);
        post_lit("t1_readdata",   32'(cap_rd), 32'h11);
        post_lit("t1_busy_cycles", 32'(busy_cnt - b), 32'd3);

        // Store hit then load hit, no memory traffic
        b = busy_cnt; w = wb_cnt; f = fetch_cnt;
        do_req(1'b1, 8'h01, 8'hAA, 0, 0);
        do_req(1'b0, 8'h01, 8'h00, 0, 0);
        post_lit("t2_readdata",   32'(cap_rd), 32'hAA);
        post_lit("t2_busy_cycles", 32'(busy_cnt - b), 32'd0);
        post_lit("t2_mem_cycles", 32'(wb_cnt - w + fetch_cnt - f), 32'd0);

        // Dirty eviction of LRU tag 0
        do_req(1'b0, 8'h10, 8'h00, 0, 0);
        w = wb_cnt;
        do_req(1'b0, 8'h20, 8'h00, 0, 0);
        post_lit("t3_wb_cycles", 32'(wb_cnt - w), 32'd1);
        post_lit("t3_wb_addr",   32'(cap_wb_addr), 32'h00);
        post_lit("t3_wb_data",   cap_wb_data, 32'h4433AA11);
        post_lit("t3_fetch_addr", 32'(cap_fetch), 32'h08);

        // A hit on 0x00 makes 0x10 the victim
        do_reset();
        do_req(1'b0, 8'h00, 8'h00, 0, 0);
        do_req(1'b0, 8'h10, 8'h00, 0, 0);
        do_req(1'b0, 8'h00, 8'h00, 0, 0);
        w = wb_cnt;
        do_req(1'b0, 8'h20, 8'h00, 0, 0);
        post_lit("t4_wb_cycles", 32'(wb_cnt - w), 32'd0);
        post_lit("t4_fetch_addr", 32'(cap_fetch), 32'h08);
        b = busy_cnt;
        do_req(1'b0, 8'h00, 8'h00, 0, 0);
        post_lit("t4_tag0_kept", 32'(busy_cnt - b), 32'd0);
        b = busy_cnt;
        do_req(1'b0, 8'h10, 8'h00, 0, 0);
        post_lit("t4_tag1_evicted", 32'(busy_cnt - b), 32'd3);

        // Five memory wait cycles during FETCH
        b = busy_cnt; f = fetch_cnt;
        do_req(1'b0, 8'h30, 8'h00, 0, 5);
        post_lit("t5_busy_cycles", 32'(busy_cnt - b), 32'd8);
        post_lit("t5_fetch_cycles", 32'(fetch_cnt - f), 32'd6);

        // Reset during WRITEBACK
        do_req(1'b1, 8'h10, 8'h55, 0, 0);
        do_req(1'b0, 8'h30, 8'h00, 0, 0);
        vw = victim_of(2'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0);
        read = 1'b1; address = 8'h40;
        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, {m_tag[0][vw], 2'd0}, m_data[0][vw]);
        @(negedge clock);
        #2;
        chk_en = 1'b0;
        s_mw_pre = mem_write;
        reset = 1'b1;
        #1;
        s_mw = mem_write; s_ma = mem_address; s_mwd = mem_writedata;
        read = 1'b0;
        #1;
        s_busy = BUSY;
        @(posedge clock);
        #1;
        reset = 1'b0; mem_BUSY = 1'b0;
        model_reset();
        post_lit("t6_mem_write_before", 32'(s_mw_pre), 32'h1);
        post_lit("t6_mem_write_reset",  32'(s_mw), 32'h0);
        post_lit("t6_mem_address_reset", 32'(s_ma), 32'h0);
        post_lit("t6_mem_wdata_reset",  s_mwd, 32'h0);
        post_lit("t6_busy_reset",       32'(s_busy), 32'h0);
        b = busy_cnt;
        do_req(1'b0, 8'h00, 8'h00, 0, 0);
        post_lit("t6_read_misses", 32'(busy_cnt - b), 32'd3);

        // Randomized traffic over a few tags per set
        for (int n = 0; n < 400; n++) begin
            do_req(1'($urandom_range(0, 1)),
                   {4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
                   8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
